vx_muldiv_share_arb: RTL

- Shares one integer mul/div execute unit between NUM_REQS issue slices.
- Per-slice round-robin arbitration with outstanding-op credit limits; one registered request stage feeds the unit.
- Unit commit responses are routed back to the owning slice by the warp-id low bits; by construction, slice i issues only warps with wid % NUM_REQS == i.
- Sits between the per-slice dispatch queues and the shared muldiv unit, inside the core execute stage.

---
 rtl/vx_muldiv_share_arb_pkg.sv | 24 ++
 rtl/vx_muldiv_share_arb_chk.sv | 37 +++
 rtl/vx_muldiv_share_arb_rr_arbiter.sv | 36 +++
 rtl/vx_muldiv_share_arb.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vx_muldiv_share_arb_pkg.sv
// Shared definitions for the muldiv sharing arbiter: request-stage states,
// payload field placement and width helpers derived from the block parameters.
package vx_muldiv_share_arb_pkg;

    // Width of the uuid field at the top of the packed execute payload.
    localparam int UUID_WIDTH = 44;

    // One-entry request stage: it either holds a payload for the unit or not.
    typedef enum logic [0:0] {
        STAGE_EMPTY = 1'b0,
        STAGE_FULL  = 1'b1
    } stage_state_e;

    // Bits needed to name one of num_reqs slices (num_reqs is a power of 2).
    function automatic int req_sel_bits(input int num_reqs);
        return $clog2(num_reqs);
    endfunction

    // Bits needed to hold an in-flight count from 0 up to max_pending inclusive.
    function automatic int pending_cnt_bits(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/vx_muldiv_share_arb_chk.sv
// Simulation-only consistency checks on credit accounting and warp routing.
module vx_muldiv_share_arb_chk
    import vx_muldiv_share_arb_pkg::*;
#(
    parameter int NUM_REQS    = 4,
    parameter int MAX_PENDING = 4
) (
    input logic                                   clk,
    input logic                                   reset,
    input logic                                   grant,
    input logic [req_sel_bits(NUM_REQS)-1:0]      grant_index,
    input logic [req_sel_bits(NUM_REQS)-1:0]      grant_wid_lo,
    input logic                                   rsp_fire,
    input logic [req_sel_bits(NUM_REQS)-1:0]      rsp_sel,
    input logic [pending_cnt_bits(MAX_PENDING)-1:0] cnt_at_sel,
    input logic [pending_cnt_bits(MAX_PENDING)-1:0] cnt_at_grant
);

    localparam int CNT_W = pending_cnt_bits(MAX_PENDING);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    logic same_slice_s;
    assign same_slice_s = grant && rsp_fire && (grant_index == rsp_sel);

    // A commit must never arrive for a slice with nothing in flight.
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(rsp_fire && !same_slice_s && (cnt_at_sel == {CNT_W{1'b0}})));

    // A grant must never push a slice past its credit limit.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(grant && !same_slice_s && (cnt_at_grant >= CNT_MAX)));

    // Slice i only issues warps whose low wid bits equal i.
    a_wid_owner: assert property (@(posedge clk) disable iff (reset)
        grant |-> (grant_wid_lo == grant_index));

endmodule

// File: rtl/vx_muldiv_share_arb_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr,
// wrapping. The caller owns the pointer and advances it on grant.
module vx_muldiv_share_arb_rr_arbiter
    import vx_muldiv_share_arb_pkg::*;
#(
    parameter int NUM_REQS = 4
) (
    input  logic [NUM_REQS-1:0]                     requests,
    input  logic [req_sel_bits(NUM_REQS)-1:0]       ptr,
    output logic                                    grant_valid,
    output logic [req_sel_bits(NUM_REQS)-1:0]       grant_index,
    output logic [NUM_REQS-1:0]                     grant_onehot
);

    localparam int SEL_W = req_sel_bits(NUM_REQS);
    localparam logic [NUM_REQS-1:0] ONE_HOT_LSB = {{(NUM_REQS-1){1'b0}}, 1'b1};

    logic [SEL_W-1:0] idx_s;
    logic             take_s;

    // Scan from the pointer; index arithmetic wraps because NUM_REQS is a power of 2.
    always_comb begin
        grant_valid  = 1'b0;
        grant_index  = {SEL_W{1'b0}};
        idx_s        = {SEL_W{1'b0}};
        take_s       = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx_s       = ptr + SEL_W'(k);
            take_s      = !grant_valid && requests[idx_s];
            grant_index = take_s ? idx_s : grant_index;
            grant_valid = grant_valid || take_s;
        end
        grant_onehot = grant_valid ? (ONE_HOT_LSB << grant_index) : {NUM_REQS{1'b0}};
    end

endmodule

// File: rtl/vx_muldiv_share_arb.sv
// Shares one muldiv execute unit among NUM_REQS issue slices: round-robin
// arbitration with per-slice credit limits into a one-entry request stage,
// and wid-based combinational routing of commits back to the owning slice.
module vx_muldiv_share_arb
    import vx_muldiv_share_arb_pkg::*;
#(
    parameter int NUM_REQS    = 4,
    parameter int REQ_DATAW   = 256,
    parameter int RSP_DATAW   = 160,
    parameter int NW_BITS     = 4,
    parameter int MAX_PENDING = 4
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NUM_REQS-1:0]                            req_valid,
    input  logic [NUM_REQS*REQ_DATAW-1:0]                  req_data,
    output logic [NUM_REQS-1:0]                            req_ready,
    output logic                                           unit_req_valid,
    output logic [REQ_DATAW-1:0]                           unit_req_data,
    input  logic                                           unit_req_ready,
    input  logic                                           unit_rsp_valid,
    input  logic [NW_BITS-1:0]                             unit_rsp_wid,
    input  logic [RSP_DATAW-1:0]                           unit_rsp_data,
    output logic                                           unit_rsp_ready,
    output logic [NUM_REQS-1:0]                            rsp_valid,
    output logic [RSP_DATAW-1:0]                           rsp_data,
    input  logic [NUM_REQS-1:0]                            rsp_ready,
    output logic [NUM_REQS*pending_cnt_bits(MAX_PENDING)-1:0] pending_cnt
);

    localparam int SEL_W   = req_sel_bits(NUM_REQS);
    localparam int CNT_W   = pending_cnt_bits(MAX_PENDING);
    localparam int WID_LSB = REQ_DATAW - UUID_WIDTH - NW_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stage_state_e         state_r;
    stage_state_e         state_nxt_s;
    logic [REQ_DATAW-1:0] stage_data_r;
    logic [SEL_W-1:0]     ptr_r;
    logic [CNT_W-1:0]     cnt_r [NUM_REQS];

    logic [REQ_DATAW-1:0] req_arr_s [NUM_REQS];
    logic [NUM_REQS-1:0]  elig_s;
    logic [NUM_REQS-1:0]  win_onehot_s;
    logic [NUM_REQS-1:0]  rsp_fire_vec_s;
    logic                 win_valid_s;
    logic [SEL_W-1:0]     win_idx_s;
    logic [REQ_DATAW-1:0] win_data_s;
    logic                 stage_load_s;
    logic                 grant_s;
    logic [SEL_W-1:0]     sel_s;
    logic                 rsp_fire_s;
    logic                 unused_wid_s;

    // Split the flat payload bus and mask slices that have used all their credits.
    always_comb begin
        elig_s = {NUM_REQS{1'b0}};
        for (int i = 0; i < NUM_REQS; i++) begin
            req_arr_s[i] = req_data[i*REQ_DATAW +: REQ_DATAW];
            elig_s[i]    = req_valid[i] && (cnt_r[i] < CNT_MAX);
        end
    end

    vx_muldiv_share_arb_rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_rr_arbiter (
        .requests     (elig_s),
        .ptr          (ptr_r),
        .grant_valid  (win_valid_s),
        .grant_index  (win_idx_s),
        .grant_onehot (win_onehot_s)
    );

    // Accept only when the stage can take a new entry; nothing is accepted under
    // reset because the stage would drop it.
    always_comb begin
        win_data_s   = req_arr_s[win_idx_s];
        stage_load_s = (state_r == STAGE_EMPTY) || unit_req_ready;
        grant_s      = win_valid_s && stage_load_s && !reset;
        req_ready    = grant_s ? win_onehot_s : {NUM_REQS{1'b0}};
    end

    // Stage next-state: refill on grant, drain when the unit takes it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            STAGE_EMPTY: state_nxt_s = grant_s ? STAGE_FULL : STAGE_EMPTY;
            STAGE_FULL:  state_nxt_s = grant_s ? STAGE_FULL :
                                       (unit_req_ready ? STAGE_EMPTY : STAGE_FULL);
            default:     state_nxt_s = STAGE_EMPTY;
        endcase
    end

    // Stage state, payload and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= STAGE_EMPTY;
            stage_data_r <= {REQ_DATAW{1'b0}};
            ptr_r        <= {SEL_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                stage_data_r <= win_data_s;
                ptr_r        <= win_idx_s + CNT_ONE[SEL_W-1:0];
            end else begin
                stage_data_r <= stage_data_r;
                ptr_r        <= ptr_r;
            end
        end
    end

    assign unit_req_valid = (state_r == STAGE_FULL);
    assign unit_req_data  = stage_data_r;

    // Route the commit to the slice that owns the warp; zero added latency.
    always_comb begin
        sel_s          = unit_rsp_wid[SEL_W-1:0];
        rsp_valid      = {NUM_REQS{1'b0}};
        rsp_valid[sel_s] = unit_rsp_valid;
        unit_rsp_ready = rsp_ready[sel_s];
        rsp_data       = unit_rsp_data;
        rsp_fire_s     = unit_rsp_valid && unit_rsp_ready;
        rsp_fire_vec_s = rsp_valid & {NUM_REQS{unit_rsp_ready}};
    end

    // Upper wid bits only matter to the unit, not to routing.
    assign unused_wid_s = ^unit_rsp_wid;

    // Per-slice credit counters: +1 on grant, -1 on commit, unchanged if both.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                case ({req_ready[i], rsp_fire_vec_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CNT_ONE;
                    2'b01:   cnt_r[i] <= cnt_r[i] - CNT_ONE;
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Flatten the counters for the debug/perf port.
    always_comb begin
        pending_cnt = {(NUM_REQS*CNT_W){1'b0}};
        for (int i = 0; i < NUM_REQS; i++) begin
            pending_cnt[i*CNT_W +: CNT_W] = cnt_r[i];
        end
    end

    vx_muldiv_share_arb_chk #(
        .NUM_REQS    (NUM_REQS),
        .MAX_PENDING (MAX_PENDING)
    ) u_chk (
        .clk          (clk),
        .reset        (reset),
        .grant        (grant_s),
        .grant_index  (win_idx_s),
        .grant_wid_lo (win_data_s[WID_LSB +: SEL_W]),
        .rsp_fire     (rsp_fire_s),
        .rsp_sel      (sel_s),
        .cnt_at_sel   (cnt_r[sel_s]),
        .cnt_at_grant (cnt_r[win_idx_s])
    );

endmodule
